regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 Parameter CNT_W, default 16, width of the committed-write counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline flush; kills the staged write.
REQ-007 a_valid  input  1  requester A (ALU writeback) has a write.
REQ-008 a_addr  input  ADDR_W  requester A destination register.
REQ-009 a_data  input  DATA_W  requester A write data.
REQ-010 a_ready  output  1  requester A write accepted this cycle.
REQ-011 b_valid / b_addr / b_data / b_ready  same widths/directions as A  requester B (load unit).
REQ-012 rf_we  output  1  register-file write enable (registered).
REQ-013 rf_wa  output  ADDR_W  register-file write address (registered).
REQ-014 rf_wd  output  DATA_W  register-file write data (registered).
REQ-015 wr_count  output  CNT_W  count of writes committed to the register file.

Function
REQ-016 Handshake: a transfer occurs on a requester in a cycle where its valid and ready are both 1; the requester SHALL hold addr/data stable while valid=1 and ready=0.
REQ-017 Ready is combinational: X_ready = X_valid & ~flush & (X wins arbitration); at most one ready is 1 per cycle.
REQ-018 Arbitration: single contender wins unconditionally; if both valid, the requester indicated by priority pointer ptr (0=A, 1=B) wins.
REQ-019 After any transfer, ptr SHALL point to the requester that did not win; with no transfer, ptr holds.
REQ-020 Latency: a transfer in cycle N SHALL drive rf_wa/rf_wd with the winner's addr/data in cycle N+1.
REQ-021 rf_we in cycle N+1 SHALL be 1 only if a transfer occurred in cycle N and the winner's addr is nonzero; writes to register 0 are accepted and silently dropped.
REQ-022 With no transfer in cycle N, rf_we SHALL be 0 in cycle N+1 and rf_wa/rf_wd SHALL hold their previous values.
REQ-023 flush=1 in cycle N: both readies 0 in N, rf_we 0 in N+1, ptr reset to A, wr_count unchanged.
REQ-024 wr_count increments by 1 on every cycle with rf_we=1; saturates at all-ones (no wrap-around).
REQ-025 Continuous contention SHALL alternate grants A,B,A,B...; no requester waits more than one cycle while the other holds valid.

Reset
REQ-026 While rst_n=0 at a clock edge: rf_we=0, rf_wa=0, rf_wd=0, wr_count=0, ptr=A.
REQ-027 During reset, a_ready and b_ready SHALL be 0; no transfer is recorded.
REQ-028 Reset asserted in the cycle after a transfer SHALL suppress that write (rf_we=0 next edge).
REQ-029 First transfer is possible in the first cycle with rst_n=1.

Structure
REQ-030 Package regfile_pkg SHALL hold DATA_W, ADDR_W, ZERO_REG=0 and the requester-select encoding (REQ_A=0, REQ_B=1).
REQ-031 A sub-module rr_arb2 (2-way round-robin arbiter: two requests, pointer state, two one-hot grants) is natural; the output stage and counter remain in regfile_wb_arbiter.
REQ-032 rf_we/rf_wa/rf_wd connect directly to the register file write port; no other driver of that port is permitted.

Verification
REQ-033 Reset then A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; wr_count=1.
REQ-034 Both valid from reset, A addr 3/0x11, B addr 4/0x22 held 4 cycles -> grants A,B,A,B; rf_wa sequence 3,4,3,4; wr_count=4.
REQ-035 B writes addr 0, data 0xFFFFFFFF -> b_ready=1, next cycle rf_we=0, wr_count unchanged, ptr points to A.
REQ-036 flush=1 with both valid -> both readies 0, rf_we=0 next cycle; following cycle with both valid grants A.
REQ-037 Transfer in cycle N, rst_n=0 in N+1 -> rf_we=0, rf_wa=0, rf_wd=0, wr_count=0 after that edge.
REQ-038 Preload wr_count to 0xFFFE via 2^16-2 writes, then 3 more writes -> wr_count stays 0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared widths and requester-select encoding for the
//               register-file writeback arbiter.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter with one-hot grants and a
//           clearable priority pointer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  import regfile_pkg::REQ_A;
  import regfile_pkg::REQ_B;

  logic r_ptr;
  logic w_en;
  logic w_gnt_a;
  logic w_gnt_b;

  // No grant may be issued while in reset or during a flush.
  assign w_en = rst_n & ~i_clr;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_en) begin
      if (i_req[0] && i_req[1]) begin
        w_gnt_a = (r_ptr == REQ_A);
        w_gnt_b = (r_ptr == REQ_B);
      end else begin
        w_gnt_a = i_req[0];
        w_gnt_b = i_req[1];
      end
    end
  end

  assign o_gnt = {w_gnt_b, w_gnt_a};

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_ptr <= REQ_A;
    end else if (w_gnt_a) begin
      r_ptr <= REQ_B;
    end else if (w_gnt_b) begin
      r_ptr <= REQ_A;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : arbitrates ALU and load-unit writebacks onto a single
//                      registered register-file write port.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [CNT_W-1:0]  wr_count
);
  import regfile_pkg::ZERO_REG;

  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [CNT_W-1:0]  r_cnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_req ({b_valid, a_valid}),
    .o_gnt (w_gnt)
  );

  assign a_ready = w_gnt[0];
  assign b_ready = w_gnt[1];
  assign w_xfer  = w_gnt[0] | w_gnt[1];
  assign w_addr  = w_gnt[1] ? b_addr : a_addr;
  assign w_data  = w_gnt[1] ? b_data : a_data;

  // Writes to the zero register complete the handshake but never reach the file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_xfer && (w_addr != ADDR_W'(ZERO_REG));
      if (w_xfer) begin
        r_wa <= w_addr;
        r_wd <= w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_we && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rf_we    = r_we;
  assign rf_wa    = r_wa;
  assign rf_wd    = r_wd;
  assign wr_count = r_cnt;

endmodule

`default_nettype wire
